// File: rtl/timer_ctrl_pkg.sv
// Shared encodings for the timer controller: FSM state codes and run-mode constants.
package timer_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_ctrl_tick_gen.sv
// Prescaler: counts 0..presc while enabled and flags the edge where it wraps.
module tick_gen #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);
  localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

  logic [PRESC_W-1:0] r_cnt;

  assign o_tick = i_enable && (r_cnt == i_presc);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= o_tick ? '0 : r_cnt + ONE;
  end
endmodule

// File: rtl/timer_ctrl.sv
// Programmable one-shot/periodic timer: FSM, latched configuration and count logic
// around a single prescaler instance.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t             r_state, w_next;
  logic [WIDTH-1:0]   r_count, r_lim;
  logic [PRESC_W-1:0] r_presc;
  logic               r_mode, r_done;
  logic               w_start_ok, w_count_en, w_clear, w_tick, w_terminal;

  // start is only honoured from a resting state, and stop always wins over it
  assign w_start_ok = start && !stop && ((r_state == IDLE) || (r_state == DONE));
  // HOLD with pause released counts on that same edge, so a pause costs exactly its length
  assign w_count_en = ((r_state == RUN) || (r_state == HOLD)) && !stop && !pause;
  assign w_clear    = stop || w_start_ok;
  assign w_terminal = w_tick && (r_count == r_lim);

  tick_gen #(.PRESC_W(PRESC_W)) u_tick (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_enable (w_count_en),
    .i_clear  (w_clear),
    .i_presc  (r_presc),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_start_ok) w_next = RUN;
      RUN, HOLD: begin
        if (stop)                                         w_next = IDLE;
        else if (pause)                                   w_next = HOLD;
        else if (w_terminal && (r_mode == MODE_ONESHOT))  w_next = DONE;
        else                                              w_next = RUN;
      end
      DONE: begin
        if (stop)            w_next = IDLE;
        else if (w_start_ok) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = (r_state == RUN) || (r_state == HOLD);
    state = r_state;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_lim   <= '0;
      r_presc <= '0;
      r_mode  <= MODE_ONESHOT;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_terminal;
      if (stop) begin
        r_count <= '0;
      end else if (w_start_ok) begin
        r_count <= '0;
        r_lim   <= load_val;
        r_presc <= presc;
        r_mode  <= mode;
      end else if (w_tick) begin
        if (r_count == r_lim) begin
          if (r_mode == MODE_PERIODIC) r_count <= '0;
        end else if (r_count < r_lim) begin
          r_count <= r_count + ONE;
        end
      end
    end
  end

  assign count = r_count;
  assign done  = r_done;
endmodule

// File: tb/tb_timer_ctrl.sv
// Scoreboard bench for timer_ctrl: directed stimulus pushes expected outputs, a monitor pops and compares.
module tb_timer_ctrl;
  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  count;
  logic          busy, done;
  logic [1:0]    state;

  typedef struct {
    logic [W-1:0] c;
    logic         b;
    logic         d;
    logic [1:0]   s;
    string        nm;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  timer_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .load_val (load_val),
    .presc    (presc),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, want finish");
    $fatal(1, "timeout");
  end

  // monitor: one expected entry per observed edge (clock or async reset)
  initial begin
    forever begin
      exp_t e;
      @(posedge clk or negedge reset_n);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_vec++;
        if ({count, busy, done, state} !== {e.c, e.b, e.d, e.s}) begin
          n_err++;
          $display("FAIL %s: got count=%0d busy=%0b done=%0b state=%0d, want count=%0d busy=%0b done=%0b state=%0d",
                   e.nm, count, busy, done, state, e.c, e.b, e.d, e.s);
        end
      end
    end
  end

  task automatic push_exp(input int c, input logic b, input logic d, input int s, input string nm);
    exp_t e;
    e.c  = W'(c);
    e.b  = b;
    e.d  = d;
    e.s  = 2'(s);
    e.nm = nm;
    q.push_back(e);
  endtask

  // drive one cycle of control inputs at a falling edge; expectation is for after the next rising edge
  task automatic cyc(input logic st, input logic sp, input logic pa,
                     input int c, input logic b, input logic d, input int s, input string nm);
    start = st;
    stop  = sp;
    pause = pa;
    push_exp(c, b, d, s, nm);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, "reset_state");
    reset_n = 1'b1;
    cyc(1, 1, 0, 0, 0, 0, 0, "start_stop_idle");

    // one-shot lim=3 presc=0; config scrambled after the start edge
    mode = 1'b0; load_val = 4'd3; presc = 4'd0;
    cyc(1, 0, 0, 0, 1, 0, 1, "os_start");
    mode = 1'b1; load_val = 4'd9; presc = 4'd5;
    cyc(0, 0, 0, 1, 1, 0, 1, "os_c1");
    cyc(0, 0, 0, 2, 1, 0, 1, "os_c2");
    cyc(0, 0, 0, 3, 1, 0, 1, "os_c3");
    cyc(0, 0, 0, 3, 0, 1, 3, "os_done");
    cyc(0, 0, 0, 3, 0, 0, 3, "os_hold");

    // restart from DONE with lim=1
    mode = 1'b0; load_val = 4'd1; presc = 4'd0;
    cyc(1, 0, 0, 0, 1, 0, 1, "rs_start");
    cyc(0, 0, 0, 1, 1, 0, 1, "rs_c1");
    cyc(0, 0, 0, 1, 0, 1, 3, "rs_done");
    cyc(0, 1, 0, 0, 0, 0, 0, "stop_in_done");

    // periodic lim=2 presc=1: count 0,0,1,1,2,2,0.. done every 6 clocks
    mode = 1'b1; load_val = 4'd2; presc = 4'd1;
    cyc(1, 0, 0, 0, 1, 0, 1, "per_start");
    for (int k = 1; k <= 12; k++)
      cyc(0, 0, 0, (k / 2) % 3, 1, (k % 6 == 0), 1, "per_run");
    cyc(0, 1, 0, 0, 0, 0, 0, "per_stop");

    // periodic lim=0 presc=0: done stays high; stop on a terminal edge suppresses it
    load_val = 4'd0; presc = 4'd0;
    cyc(1, 0, 0, 0, 1, 0, 1, "p0_start");
    repeat (4) cyc(0, 0, 0, 0, 1, 1, 1, "p0_done_hi");
    cyc(0, 1, 0, 0, 0, 0, 0, "stop_terminal");

    // pause 5 cycles at count=1: done lands 5 cycles late
    mode = 1'b0; load_val = 4'd3; presc = 4'd0;
    cyc(1, 0, 0, 0, 1, 0, 1, "pz_start");
    cyc(0, 0, 0, 1, 1, 0, 1, "pz_c1");
    repeat (5) cyc(0, 0, 1, 1, 1, 0, 2, "pz_hold");
    cyc(0, 0, 0, 2, 1, 0, 1, "pz_resume");
    cyc(0, 0, 0, 3, 1, 0, 1, "pz_c3");
    cyc(0, 0, 0, 3, 0, 1, 3, "pz_done");
    cyc(0, 1, 0, 0, 0, 0, 0, "pz_stop");

    // start in RUN ignored; new load_val mid-run ignored
    cyc(1, 0, 0, 0, 1, 0, 1, "pr_start");
    load_val = 4'd1;
    cyc(1, 0, 0, 1, 1, 0, 1, "start_in_run");
    cyc(0, 0, 0, 2, 1, 0, 1, "orig_lim");
    cyc(0, 0, 0, 3, 1, 0, 1, "pr_c3");
    cyc(0, 0, 0, 3, 0, 1, 3, "pr_done");

    // async reset mid-RUN at count=2
    load_val = 4'd3;
    cyc(1, 0, 0, 0, 1, 0, 1, "ar_start");
    cyc(0, 0, 0, 1, 1, 0, 1, "ar_c1");
    cyc(0, 0, 0, 2, 1, 0, 1, "ar_c2");
    push_exp(0, 0, 0, 0, "async_rst");
    #2 reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, "rst_no_done");
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, "idle_after_rst");

    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
